foo_slot_tracker: RTL and testbench

Per-slot lifecycle tracker that produces the packed 2-bit-per-slot status words consumed by the inactive-slot decoder. Each slot steps through IDLE → ALLOC → BUSY → DRAIN → IDLE in response to allocate, start and done events. The block drives both the registered status word (`o_foo_current`) and its combinational next-state word (`o_foo_next`), so the downstream decoder can produce both current and look-ahead inactive masks.

---
 rtl/foo_slot_tracker_if.sv | 29 ++
 rtl/foo_slot_tracker.sv | 136 +++++++++++++
 tb/tb_foo_slot_tracker.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/foo_slot_tracker_if.sv
// Event/status bundle between a slot-tracker client and foo_slot_tracker.
// The client (master) raises alloc/start/done events. The tracker (slave)
// returns the allocation grant, the packed status words, the busy count
// and the error pulse.
interface foo_slot_tracker_if;
  logic        i_alloc_valid;
  logic        o_alloc_ready;
  logic [3:0]  o_alloc_id;
  logic        i_start_valid;
  logic [3:0]  i_start_id;
  logic        i_done_valid;
  logic [3:0]  i_done_id;
  logic [31:0] o_foo_current;
  logic [31:0] o_foo_next;
  logic [4:0]  o_busy_count;
  logic        o_err;

  modport master (
    output i_alloc_valid, i_start_valid, i_start_id, i_done_valid, i_done_id,
    input  o_alloc_ready, o_alloc_id, o_foo_current, o_foo_next,
           o_busy_count, o_err
  );

  modport slave (
    input  i_alloc_valid, i_start_valid, i_start_id, i_done_valid, i_done_id,
    output o_alloc_ready, o_alloc_id, o_foo_current, o_foo_next,
           o_busy_count, o_err
  );
endinterface

// File: rtl/foo_slot_tracker.sv
// Per-slot lifecycle tracker: IDLE -> ALLOC -> BUSY -> DRAIN -> IDLE.
// It publishes the registered packed status word and its combinational
// look-ahead, so a downstream decoder can build current and next masks.
module foo_slot_tracker #(
  parameter int NUM_SLOTS    = 7,  // 1..16
  parameter int DRAIN_CYCLES = 4   // 1..15
) (
  input logic               i_clk,
  input logic               i_rst,
  foo_slot_tracker_if.slave bus
);

  typedef enum logic [1:0] {
    SLOT_IDLE  = 2'd0,
    SLOT_ALLOC = 2'd1,
    SLOT_BUSY  = 2'd2,
    SLOT_DRAIN = 2'd3
  } slot_state_e;

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);

  slot_state_e          state_q [NUM_SLOTS];
  slot_state_e          state_d [NUM_SLOTS];
  logic [3:0]           cnt_q   [NUM_SLOTS];
  logic [3:0]           cnt_d   [NUM_SLOTS];
  logic [4:0]           busy_count_q, busy_count_d;
  logic                 err_q, err_d;

  logic [NUM_SLOTS-1:0] idle_mask, alloc_mask, busy_mask;
  logic [NUM_SLOTS-1:0] start_hit, done_hit;
  logic [31:0]          cur_word, next_word;
  logic                 alloc_ready;
  logic [3:0]           alloc_id;
  logic                 alloc_fire, start_ok, done_ok;

  // Decode the current state: per-slot masks, event targets, packed status
  // and the lowest-index IDLE slot. Nothing here depends on i_alloc_valid.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch so
    // no path leaves it unassigned, which would infer a latch.
    idle_mask   = '0;
    alloc_mask  = '0;
    busy_mask   = '0;
    start_hit   = '0;
    done_hit    = '0;
    cur_word    = '0;
    alloc_id    = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      idle_mask[k]       = (state_q[k] == SLOT_IDLE);
      alloc_mask[k]      = (state_q[k] == SLOT_ALLOC);
      busy_mask[k]       = (state_q[k] == SLOT_BUSY);
      // Out-of-range ids match no slot, so they fall out as illegal below.
      start_hit[k]       = bus.i_start_valid && (bus.i_start_id == 4'(k));
      done_hit[k]        = bus.i_done_valid  && (bus.i_done_id  == 4'(k));
      cur_word[2*k +: 2] = state_q[k];
    end
    // Scan downward so the last hit is the lowest index.
    for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
      if (idle_mask[k]) alloc_id = 4'(k);
    end
    alloc_ready = |idle_mask;
  end

  // Next-state for every slot, error detection and the look-ahead word.
  always_comb begin
    alloc_fire = bus.i_alloc_valid && alloc_ready;
    // Both checks use the current state, so start+done on one slot, or an
    // event aimed at the slot being allocated, is rejected automatically.
    start_ok   = |(start_hit & alloc_mask);
    done_ok    = |(done_hit & busy_mask);
    err_d      = (bus.i_start_valid && !start_ok) ||
                 (bus.i_done_valid  && !done_ok);
    next_word    = '0;
    busy_count_d = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      state_d[k] = state_q[k];
      cnt_d[k]   = cnt_q[k];
      unique case (state_q[k])
        SLOT_IDLE:  if (alloc_fire && (alloc_id == 4'(k))) state_d[k] = SLOT_ALLOC;
        SLOT_ALLOC: if (start_hit[k]) state_d[k] = SLOT_BUSY;
        SLOT_BUSY: begin
          if (done_hit[k]) begin
            state_d[k] = SLOT_DRAIN;
            cnt_d[k]   = DRAIN_LOAD;
          end
        end
        SLOT_DRAIN: begin
          if (cnt_q[k] <= 4'd1) begin
            state_d[k] = SLOT_IDLE;
            cnt_d[k]   = 4'd0;
          end else begin
            cnt_d[k]   = cnt_q[k] - 4'd1;
          end
        end
        default: state_d[k] = SLOT_IDLE;
      endcase
      if (i_rst) begin
        state_d[k] = SLOT_IDLE;
        cnt_d[k]   = 4'd0;
      end
      next_word[2*k +: 2] = state_d[k];
      busy_count_d        = busy_count_d + 5'(state_d[k] == SLOT_BUSY);
    end
  end

  // State register: slot states, drain counters, busy count and error pulse.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (i_rst) begin
      // NOTE: the per-slot arrays are control state, not storage, so they
      // are reset like any other flop.
      for (int k = 0; k < NUM_SLOTS; k++) begin
        state_q[k] <= SLOT_IDLE;
        cnt_q[k]   <= 4'd0;
      end
      busy_count_q <= 5'd0;
      err_q        <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_SLOTS; k++) begin
        state_q[k] <= state_d[k];
        cnt_q[k]   <= cnt_d[k];
      end
      busy_count_q <= busy_count_d;
      err_q        <= err_d;
    end
  end

  assign bus.o_alloc_ready = alloc_ready;
  assign bus.o_alloc_id    = alloc_id;
  assign bus.o_foo_current = cur_word;
  assign bus.o_foo_next    = next_word;
  assign bus.o_busy_count  = busy_count_q;
  assign bus.o_err         = err_q;

endmodule

// File: tb/tb_foo_slot_tracker.sv
// Directed bench for foo_slot_tracker (NUM_SLOTS=7, DRAIN_CYCLES=4).
// Inputs change and outputs are sampled 1 ns after the rising edge.
module tb_foo_slot_tracker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec  = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;

  foo_slot_tracker_if bus ();

  foo_slot_tracker #(.NUM_SLOTS(7), .DRAIN_CYCLES(4)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_events();
    bus.i_alloc_valid = 1'b0;
    bus.i_start_valid = 1'b0;
    bus.i_start_id    = 4'd0;
    bus.i_done_valid  = 1'b0;
    bus.i_done_id     = 4'd0;
  endtask

  task automatic do_reset();
    clear_events();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic start_ev(input logic [3:0] id);
    bus.i_start_valid = 1'b1;
    bus.i_start_id    = id;
  endtask

  task automatic done_ev(input logic [3:0] id);
    bus.i_done_valid = 1'b1;
    bus.i_done_id    = id;
  endtask

  function automatic logic [1:0] slot_of(input logic [31:0] w, input int k);
    return w[2*k +: 2];
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    clear_events();
    tick();
    // Events during reset are ignored and the look-ahead word is zero.
    bus.i_alloc_valid = 1'b1;
    start_ev(4'd0);
    #1;
    check("rst_next", bus.o_foo_next, 32'h0);
    tick();
    rst = 1'b0;
    clear_events();
    #1;
    check("rst_cur",   bus.o_foo_current, 32'h0);
    check("rst_busy",  32'(bus.o_busy_count), 32'd0);
    check("rst_err",   32'(bus.o_err), 32'd0);
    check("rst_ready", 32'(bus.o_alloc_ready), 32'd1);
    check("rst_id",    32'(bus.o_alloc_id), 32'd0);

    // Allocate every slot with alloc held high for 8 cycles.
    bus.i_alloc_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      check("fill_ready", 32'(bus.o_alloc_ready), 32'd1);
      check("fill_id",    32'(bus.o_alloc_id), 32'(i));
      tick();
    end
    check("full_ready", 32'(bus.o_alloc_ready), 32'd0);
    check("full_cur",   bus.o_foo_current, 32'h0000_1555);
    check("stall_next", bus.o_foo_next, 32'h0000_1555);
    tick();
    check("stall_cur",  bus.o_foo_current, 32'h0000_1555);
    check("stall_err",  32'(bus.o_err), 32'd0);

    // Full lifecycle of slot 0.
    do_reset();
    bus.i_alloc_valid = 1'b1;
    #1;
    check("life_alloc_next", bus.o_foo_next, 32'h1);
    tick();
    clear_events();
    check("life_alloc", 32'(slot_of(bus.o_foo_current, 0)), 32'd1);
    check("life_alloc_busy", 32'(bus.o_busy_count), 32'd0);
    start_ev(4'd0);
    #1;
    check("life_start_next", bus.o_foo_next, 32'h2);
    tick();
    clear_events();
    check("life_busy", 32'(slot_of(bus.o_foo_current, 0)), 32'd2);
    check("life_busy_cnt", 32'(bus.o_busy_count), 32'd1);
    done_ev(4'd0);
    tick();
    clear_events();
    for (int i = 0; i < 4; i++) begin
      check("life_drain", 32'(slot_of(bus.o_foo_current, 0)), 32'd3);
      check("life_drain_busy", 32'(bus.o_busy_count), 32'd0);
      tick();
    end
    check("life_idle", 32'(slot_of(bus.o_foo_current, 0)), 32'd0);
    check("life_idle_ready", 32'(bus.o_alloc_ready), 32'd1);

    // Illegal events: start on IDLE slot 3, done on out-of-range slot 9.
    start_ev(4'd3);
    tick();
    clear_events();
    check("ill_start_err", 32'(bus.o_err), 32'd1);
    check("ill_start_cur", bus.o_foo_current, 32'h0);
    tick();
    check("ill_start_pulse", 32'(bus.o_err), 32'd0);
    done_ev(4'd9);
    tick();
    clear_events();
    check("ill_done_err", 32'(bus.o_err), 32'd1);
    check("ill_done_cur", bus.o_foo_current, 32'h0);
    tick();
    check("ill_done_pulse", 32'(bus.o_err), 32'd0);

    // Build slots 0-2 BUSY, slot 3 IDLE, slot 4 ALLOC.
    do_reset();
    bus.i_alloc_valid = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    clear_events();
    start_ev(4'd3);
    tick();
    clear_events();
    start_ev(4'd0);
    done_ev(4'd3);
    tick();
    clear_events();
    start_ev(4'd1);
    tick();
    clear_events();
    start_ev(4'd2);
    tick();
    clear_events();
    tick();
    tick();
    check("sim_setup_cur",  bus.o_foo_current, 32'h0000_012A);
    check("sim_setup_busy", 32'(bus.o_busy_count), 32'd3);
    check("sim_setup_id",   32'(bus.o_alloc_id), 32'd3);
    bus.i_alloc_valid = 1'b1;
    start_ev(4'd4);
    done_ev(4'd1);
    #1;
    check("sim_next", bus.o_foo_next, 32'h0000_026E);
    tick();
    clear_events();
    check("sim_cur",  bus.o_foo_current, 32'h0000_026E);
    check("sim_busy", 32'(bus.o_busy_count), 32'd3);
    check("sim_err",  32'(bus.o_err), 32'd0);

    // Reset while slots 0 and 5 are draining.
    do_reset();
    bus.i_alloc_valid = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    clear_events();
    start_ev(4'd0);
    tick();
    clear_events();
    check("mid_busy1", 32'(bus.o_busy_count), 32'd1);
    start_ev(4'd5);
    done_ev(4'd0);
    tick();
    clear_events();
    done_ev(4'd5);
    tick();
    clear_events();
    tick();
    check("mid_drain_cur", bus.o_foo_current, 32'h0000_0D57);
    rst = 1'b1;
    #1;
    check("mid_rst_next", bus.o_foo_next, 32'h0);
    tick();
    rst = 1'b0;
    check("mid_rst_cur",   bus.o_foo_current, 32'h0);
    check("mid_rst_busy",  32'(bus.o_busy_count), 32'd0);
    check("mid_rst_id",    32'(bus.o_alloc_id), 32'd0);
    check("mid_rst_ready", 32'(bus.o_alloc_ready), 32'd1);
    tick();
    tick();
    check("mid_rst_hold", bus.o_foo_current, 32'h0);

    // Lowest-index selection as slots 5 then 2 return to IDLE.
    do_reset();
    bus.i_alloc_valid = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    clear_events();
    check("low_full_ready", 32'(bus.o_alloc_ready), 32'd0);
    start_ev(4'd5);
    tick();
    clear_events();
    done_ev(4'd5);
    tick();
    clear_events();
    for (int i = 0; i < 4; i++) begin
      check("low_drain5_ready", 32'(bus.o_alloc_ready), 32'd0);
      tick();
    end
    check("low5_ready", 32'(bus.o_alloc_ready), 32'd1);
    check("low5_id",    32'(bus.o_alloc_id), 32'd5);
    start_ev(4'd2);
    tick();
    clear_events();
    done_ev(4'd2);
    tick();
    clear_events();
    for (int i = 0; i < 4; i++) tick();
    check("low2_id",  32'(bus.o_alloc_id), 32'd2);
    check("low2_cur", bus.o_foo_current, 32'h0000_1145);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
